wb_arbiter_2m1s: RTL and testbench
==================================

Name: wb_arbiter_2m1s

Overview:
- Wishbone arbiter between the CPU's two bus masters and one shared slave port (memory/peripheral interconnect).
- Master 0 is the instruction-fetch bus interface; master 1 is the data bus interface.
- Registered two-way round-robin grant, held for the whole cycle (CYC high).
- Combinational address/data/control muxing from the granted master to the slave, and ack/data back to it.

Parameters:
- DW, 32, data bus width.
- AW, 32, address bus width.
- TIMEOUT_CYCLES, 255, cycles without slave ack before a timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- m0_adr_i  in  AW  instruction master address
- m0_dat_i  in  DW  instruction master write data
- m0_we_i  in  1  instruction master write enable
- m0_sel_i  in  4  instruction master byte select
- m0_stb_i  in  1  instruction master strobe
- m0_cyc_i  in  1  instruction master cycle
- m0_dat_o  out  DW  read data to instruction master
- m0_ack_o  out  1  ack to instruction master
- m1_adr_i, m1_dat_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i  in  as m0  data master request
- m1_dat_o  out  DW  read data to data master
- m1_ack_o  out  1  ack to data master
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_we_o  out  1  slave write enable
- s_sel_o  out  4  slave byte select
- s_stb_o  out  1  slave strobe
- s_cyc_o  out  1  slave cycle
- s_dat_i  in  DW  slave read data
- s_ack_i  in  1  slave ack
- grant_o  out  2  one-hot grant; bit0 = m0, bit1 = m1
- bus_err_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state IDLE, grant_o=00, last_served=m0, bus_err_o=0.
  - All slave outputs 0, both m*_ack_o=0, m*_dat_o=0.
- State register, transitions at each clk edge:
  - IDLE: m1_cyc_i & m0_cyc_i -> grant the master not equal to last_served. Only one cyc high -> that master. Neither -> stay IDLE.
  - GNT0 / GNT1: stay while the granted master's cyc_i=1.
  - Granted cyc_i drops while the other master's cyc_i=1 -> move directly to the other grant (no idle gap).
  - Granted cyc_i drops with no other request -> IDLE.
  - last_served updates to the released master on every grant release.
- Latency:
  - Request at cycle N with arbiter IDLE -> s_cyc_o/s_stb_o asserted at N+1.
  - Handoff: the new master's signals appear at the slave the cycle after the old cyc_i drops.
- Muxing (combinational):
  - In GNTx, s_adr/dat/we/sel/stb/cyc_o = mx_*_i.
  - In IDLE all slave outputs are 0.
- Ack and read data:
  - mx_ack_o = s_ack_i & grant_o[x] & mx_stb_i & mx_cyc_i.
  - mx_dat_o = s_dat_i when grant_o[x], else 0.
  - The non-granted master never sees ack.
- Abort:
  - The granted master may drop cyc_i before ack (pipeline flush). The grant is released on that edge.
  - A late s_ack_i arriving after release is discarded: it must not reach either master.
- Back-to-back transfers: a master holding cyc_i with multiple stb/ack beats keeps the grant throughout (no preemption).
- Simultaneous release of m0 and new request from m1 in the same cycle -> GNT1 next cycle.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on grant change or on s_ack_i.
  - Counter increments each cycle the granted master has stb_i=1 and s_ack_i=0.
  - When the count reaches TIMEOUT_CYCLES, for one cycle: mx_ack_o=1, mx_dat_o=0, bus_err_o=1, s_cyc_o=s_stb_o=0. The counter then clears.
  - Grant is kept; the master then drops cyc normally.
- Undefined: no counter logic; bus_err_o tied 0.

Decomposition:
- Shared package wb_arb_pkg holds:
  - state encoding IDLE/GNT0/GNT1;
  - grant one-hot constants GRANT_NONE/GRANT_M0/GRANT_M1;
  - default DW/AW.
- One sub-module is natural: wb_arb_timeout (counter plus compare), instantiated only under WB_ARB_TIMEOUT_EN.

Test Plan:
- Reset: rst=1 for 2 cycles with both cyc high -> grant_o=00, s_cyc_o=0, acks 0. After release, grant_o=10 (m1; last_served=m0 at reset).
- Single read: m0 cyc/stb adr=0x00000100, slave acks 2 cycles later with dat 0x3C011234 -> m0_ack_o=1, m0_dat_o=0x3C011234, m1_ack_o=0.
- Contention: both request continuously, each releases after its ack -> grants alternate 10, 01, 10, 01. No idle cycle between grants.
- Abort: m1 drops cyc one cycle after grant; slave acks the cycle after -> m1_ack_o and m0_ack_o stay 0. Grant passes to a pending m0.
- Write pass-through: m1 we=1, sel=0011, adr=0x00001004, dat=0xDEADBEEF -> slave sees identical values while GNT1.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never acks -> after 4 stalled cycles m0_ack_o=1, m0_dat_o=0, bus_err_o=1 for exactly one cycle.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encoding,
// one-hot grant constants and default bus widths.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 32;

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall counter for the arbiter: pulses timeout for one cycle once the
// granted master has waited TIMEOUT_CYCLES cycles without a slave ack.
module wb_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic stall,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign timeout = (count == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || clear || timeout) begin
            count <= '0;
        end else if (stall) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter_2m1s.sv
// Two-master / one-slave Wishbone arbiter with registered round-robin grant.
// Optional slave timeout (bus_err_o pulse) enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m1s
    import wb_arb_pkg::*;
#(
    parameter int DW             = DEF_DW,
    parameter int AW             = DEF_AW,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_stb_i,
    input  logic          m0_cyc_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_stb_i,
    input  logic          m1_cyc_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic          s_stb_o,
    output logic          s_cyc_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    grant_o,
    output logic          bus_err_o
);

    arb_state_t    state, state_next;
    logic          last_served;   // 0 = m0, 1 = m1
    logic          release_gnt;
    logic          outstanding;
    logic          ack_discard;
    logic          tmo;
    logic [AW-1:0] mux_adr;
    logic [DW-1:0] mux_dat;
    logic          mux_we, mux_stb, mux_cyc;
    logic [3:0]    mux_sel;

    always_comb begin
        state_next  = state;
        release_gnt = 1'b0;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_next = last_served ? GNT0 : GNT1;
                else if (m0_cyc_i)        state_next = GNT0;
                else if (m1_cyc_i)        state_next = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    release_gnt = 1'b1;
                    state_next  = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    release_gnt = 1'b1;
                    state_next  = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A release with a beat still unacked is an abort; the slave's ack in the
    // following cycle belongs to the aborted beat and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= 1'b0;
            outstanding <= 1'b0;
            ack_discard <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= mux_cyc & mux_stb & ~s_ack_i;
            ack_discard <= release_gnt & outstanding;
            if (release_gnt) last_served <= (state == GNT1);
        end
    end

    always_comb begin
        grant_o = GRANT_NONE;
        mux_adr = '0;
        mux_dat = '0;
        mux_we  = 1'b0;
        mux_sel = '0;
        mux_stb = 1'b0;
        mux_cyc = 1'b0;
        case (state)
            GNT0: begin
                grant_o = GRANT_M0;
                mux_adr = m0_adr_i;
                mux_dat = m0_dat_i;
                mux_we  = m0_we_i;
                mux_sel = m0_sel_i;
                mux_stb = m0_stb_i;
                mux_cyc = m0_cyc_i;
            end
            GNT1: begin
                grant_o = GRANT_M1;
                mux_adr = m1_adr_i;
                mux_dat = m1_dat_i;
                mux_we  = m1_we_i;
                mux_sel = m1_sel_i;
                mux_stb = m1_stb_i;
                mux_cyc = m1_cyc_i;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state_next != state) | s_ack_i),
        .stall   (mux_cyc & mux_stb & ~s_ack_i),
        .timeout (tmo)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign tmo            = 1'b0;
`endif

    assign bus_err_o = tmo;

    assign s_adr_o = mux_adr;
    assign s_dat_o = mux_dat;
    assign s_we_o  = mux_we;
    assign s_sel_o = mux_sel;
    assign s_stb_o = mux_stb & ~tmo;
    assign s_cyc_o = mux_cyc & ~tmo;

    assign m0_ack_o = (s_ack_i & grant_o[0] & m0_stb_i & m0_cyc_i & ~ack_discard) | (tmo & grant_o[0]);
    assign m1_ack_o = (s_ack_i & grant_o[1] & m1_stb_i & m1_cyc_i & ~ack_discard) | (tmo & grant_o[1]);
    assign m0_dat_o = (grant_o[0] && !tmo) ? s_dat_i : '0;
    assign m1_dat_o = (grant_o[1] && !tmo) ? s_dat_i : '0;

endmodule

// File: tb/tb_wb_arbiter_2m1s.sv
// Self-checking bench for wb_arbiter_2m1s: per-cycle vector table plus a
// stall sequence whose expectations depend on WB_ARB_TIMEOUT_EN.
module tb_wb_arbiter_2m1s;

    localparam int TMO = 4;

    localparam logic [31:0] M0_ADR = 32'h0000_0100;
    localparam logic [31:0] M0_DAT = 32'h1111_2222;
    localparam logic [31:0] M1_ADR = 32'h0000_1004;
    localparam logic [31:0] M1_DAT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_adr_i = M0_ADR, m0_dat_i = M0_DAT, m1_adr_i = M1_ADR, m1_dat_i = M1_DAT;
    logic        m0_we_i = 1'b0, m1_we_i = 1'b1;
    logic [3:0]  m0_sel_i = 4'hF, m1_sel_i = 4'h3;
    logic        m0_stb_i = 1'b1, m0_cyc_i = 1'b1, m1_stb_i = 1'b1, m1_cyc_i = 1'b1;
    logic [31:0] s_dat_i = '0;
    logic        s_ack_i = 1'b0;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic        m0_ack_o, m1_ack_o, s_we_o, s_stb_o, s_cyc_o, bus_err_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  grant_o;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    always #5 clk = ~clk;

    wb_arbiter_2m1s #(
        .DW(32), .AW(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .bus_err_o(bus_err_o)
    );

    typedef struct {
        logic        rst, c0, s0, c1, s1, ack;
        logic [31:0] sdat;
        logic [1:0]  eg;
        logic        ea0, ea1, tmo;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(logic r, logic c0, logic s0, logic c1, logic s1, logic ack,
                                logic [31:0] sd, logic [1:0] eg, logic ea0, logic ea1,
                                logic tmo = 1'b0);
        vec_t v;
        v.rst = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack;
        v.sdat = sd; v.eg = eg; v.ea0 = ea0; v.ea1 = ea1; v.tmo = tmo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc_n, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
    task automatic run_vec(input vec_t v);
        vec_t        e;
        logic [31:0] eadr, edat, ed0, ed1;
        logic        ewe, estb, ecyc;
        logic [3:0]  esel;
        @(posedge clk);
        #1;
        rst = v.rst; m0_cyc_i = v.c0; m0_stb_i = v.s0; m1_cyc_i = v.c1; m1_stb_i = v.s1;
        s_ack_i = v.ack; s_dat_i = v.sdat;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        eadr = '0; edat = '0; ewe = 1'b0; esel = '0; estb = 1'b0; ecyc = 1'b0;
        if (e.eg == 2'b01) begin
            eadr = M0_ADR; edat = M0_DAT; ewe = 1'b0; esel = 4'hF; estb = e.s0; ecyc = e.c0;
        end else if (e.eg == 2'b10) begin
            eadr = M1_ADR; edat = M1_DAT; ewe = 1'b1; esel = 4'h3; estb = e.s1; ecyc = e.c1;
        end
        if (e.tmo) begin
            estb = 1'b0; ecyc = 1'b0;
        end
        ed0 = (e.eg[0] && !e.tmo) ? e.sdat : 32'h0;
        ed1 = (e.eg[1] && !e.tmo) ? e.sdat : 32'h0;
        chk("grant",   {30'h0, grant_o},   {30'h0, e.eg});
        chk("m0_ack",  {31'h0, m0_ack_o},  {31'h0, e.ea0});
        chk("m1_ack",  {31'h0, m1_ack_o},  {31'h0, e.ea1});
        chk("m0_dat",  m0_dat_o, ed0);
        chk("m1_dat",  m1_dat_o, ed1);
        chk("s_cyc",   {31'h0, s_cyc_o},   {31'h0, ecyc});
        chk("s_stb",   {31'h0, s_stb_o},   {31'h0, estb});
        chk("s_adr",   s_adr_o, eadr);
        chk("s_dat",   s_dat_o, edat);
        chk("s_we",    {31'h0, s_we_o},    {31'h0, ewe});
        chk("s_sel",   {28'h0, s_sel_o},   {28'h0, esel});
        chk("bus_err", {31'h0, bus_err_o}, {31'h0, e.tmo});
        cyc_n++;
    endtask

    initial begin
        logic pulse;
        //            rst c0 s0 c1 s1 ack sdat           grant  a0 a1
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 32'h0,         2'b00, 0, 0)); // reset, both requesting
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 32'h0,         2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 32'h0,         2'b10, 0, 0)); // m1 first after reset
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 32'hA5A5_0001, 2'b10, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,         2'b10, 0, 0)); // m1 releases
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 32'h0,         2'b01, 0, 0)); // no idle gap
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 32'h3C01_1234, 2'b01, 1, 0)); // read data to m0
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0,         2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 32'h0,         2'b10, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,         2'b10, 0, 0)); // m1 aborts
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'hBAD0_BAD0, 2'b01, 0, 0)); // late ack dropped
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,         2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'h3C01_1234, 2'b01, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         2'b01, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         2'b00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0,         2'b00, 0, 0)); // write request, N
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0,         2'b10, 0, 0)); // N+1 at slave
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h0,         2'b10, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         2'b10, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,         2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,         2'b01, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0,         2'b01, 0, 0)); // m0 drops, m1 asks same cycle
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0,         2'b10, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h5555_AAAA, 2'b10, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         2'b10, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 32'h0,         2'b00, 0, 0)); // last_served=m1 -> m0
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 32'h0000_0001, 2'b01, 1, 0)); // burst beats, no preemption
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 32'h0000_0002, 2'b01, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 32'h0,         2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 32'h0000_0003, 2'b01, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0,         2'b01, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0,         2'b10, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         2'b10, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         2'b00, 0, 0));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Stalled slave: m0 waits with no ack.
        run_vec(mk(0, 1, 1, 0, 0, 0, 32'h0, 2'b00, 0, 0));
        for (int k = 1; k <= TMO + 2; k++) begin
`ifdef WB_ARB_TIMEOUT_EN
            pulse = (k == TMO + 1);
`else
            pulse = 1'b0;
`endif
            run_vec(mk(0, 1, 1, 0, 0, 0, 32'h7777_7777, 2'b01, pulse, 0, pulse));
        end
        run_vec(mk(0, 0, 0, 0, 0, 0, 32'h0, 2'b01, 0, 0));
        run_vec(mk(0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
